// File: rtl/line_sequence_decoder.sv
// line_sequence_decoder
// Recovers a fixed-length black/white bit sequence carried on one active video
// line. A Schmitt slicer turns luma samples into a binary level. The level is
// sampled at the middle of each bit cell and shifted in MSB-first. When the line
// is complete, the ID header is checked and the payload is presented with a
// one-cycle valid strobe.
// Optional build macro: SEQ_DET_CRC_EN adds a trailing CRC-8 (poly 0x07, init
// 0x00) over header+payload and drives the o_crc_error pulse.
module line_sequence_decoder #(
  parameter int                  DATA_W        = 10,
  parameter logic [DATA_W-1:0]   BLACK_LEVEL   = 10'h040,
  parameter logic [DATA_W-1:0]   WHITE_LEVEL   = 10'h3AC,
  parameter logic [DATA_W-1:0]   TRIGGER_WIDTH = 10'h100,
  parameter int                  LINE_SAMPLES  = 720,
`ifdef SEQ_DET_CRC_EN
  parameter int                  TOTAL_BITS    = 48,
`else
  parameter int                  TOTAL_BITS    = 40,
`endif
  parameter int                  ID_BITS       = 8,
  parameter logic [ID_BITS-1:0]  ID_VALUE      = 8'hA5,
  parameter int                  PAYLOAD_BITS  = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [DATA_W-1:0]       i_sample_in,
  input  logic                    i_sample_valid,
  input  logic                    i_line_start,
  output logic [PAYLOAD_BITS-1:0] o_payload,
  output logic                    o_payload_valid,
  output logic                    o_id_error,
  output logic                    o_crc_error,
  output logic                    o_ready,
  output logic                    o_busy
);

  localparam int SAMPLES_PER_BIT = LINE_SAMPLES / TOTAL_BITS;
  localparam int CNT_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BIT_W = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0] MID_IDX  = CNT_W'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TOTAL_BITS - 1);

  // Slicer thresholds, one bit wider than the samples so the inset cannot wrap.
  localparam logic [DATA_W:0] HI_THR = {1'b0, WHITE_LEVEL} - {1'b0, TRIGGER_WIDTH};
  localparam logic [DATA_W:0] LO_THR = {1'b0, BLACK_LEVEL} + {1'b0, TRIGGER_WIDTH};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

`ifdef SEQ_DET_CRC_EN
  localparam int MSG_W = ID_BITS + PAYLOAD_BITS;

  // Bit-serial CRC-8, poly x^8+x^2+x+1, zero init, message consumed MSB first
  // (the order the bits were transmitted on the line).
  function automatic logic [7:0] crc8_msb(input logic [MSG_W-1:0] msg);
    logic [7:0] crc;
    crc = 8'h00;
    for (int i = MSG_W - 1; i >= 0; i--) begin
      crc = {crc[6:0], 1'b0} ^ (((crc[7] ^ msg[i]) == 1'b1) ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction
`endif

  // Registers
  logic                    r_level;
  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_sample_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [TOTAL_BITS-1:0]   r_shift;
  logic                    r_busy;
  logic                    r_chk_done;
  logic                    r_chk_id_ok;
  logic [PAYLOAD_BITS-1:0] r_chk_payload;
  logic [PAYLOAD_BITS-1:0] r_payload;
  logic                    r_payload_valid;
  logic                    r_id_error;
  logic                    r_ready;
`ifdef SEQ_DET_CRC_EN
  logic                    r_chk_crc_ok;
  logic                    r_crc_error;
`endif

  // Combinational next-state values
  logic                    w_level_next;
  logic                    w_take;
  logic [CNT_W-1:0]        w_cnt_base;
  logic [BIT_W-1:0]        w_bit_base;
  logic [TOTAL_BITS-1:0]   w_shift_base;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [BIT_W-1:0]        w_bit_next;
  logic [TOTAL_BITS-1:0]   w_shift_next;
  logic [1:0]              w_state_next;
  logic [ID_BITS-1:0]      w_header;
  logic [PAYLOAD_BITS-1:0] w_payload_field;

  assign w_header        = r_shift[TOTAL_BITS-1 -: ID_BITS];
  assign w_payload_field = r_shift[TOTAL_BITS-ID_BITS-1 -: PAYLOAD_BITS];

  // Schmitt slicer: only valid samples can move the level; the band between the thresholds holds it.
  always_comb begin
    w_level_next = r_level;
    if (i_sample_valid) begin
      if (!r_level && ({1'b0, i_sample_in} > HI_THR)) begin
        w_level_next = 1'b1;
      end else if (r_level && ({1'b0, i_sample_in} < LO_THR)) begin
        w_level_next = 1'b0;
      end else begin
        w_level_next = r_level;
      end
    end else begin
      w_level_next = r_level;
    end
  end

  // Bit-cell counting and FSM next state; line_start restarts from zero and may carry sample 0.
  always_comb begin
    w_cnt_base   = i_line_start ? {CNT_W{1'b0}}      : r_sample_cnt;
    w_bit_base   = i_line_start ? {BIT_W{1'b0}}      : r_bit_cnt;
    w_shift_base = i_line_start ? {TOTAL_BITS{1'b0}} : r_shift;
    w_take       = i_sample_valid && (i_line_start || (r_state == ST_RECEIVE));
    w_cnt_next   = w_cnt_base;
    w_bit_next   = w_bit_base;
    w_shift_next = w_shift_base;

    if (i_line_start) begin
      w_state_next = ST_RECEIVE;
    end else if (r_state == ST_CHECK) begin
      w_state_next = ST_IDLE;
    end else begin
      w_state_next = r_state;
    end

    if (w_take) begin
      if (w_cnt_base == MID_IDX) begin
        w_shift_next = {w_shift_base[TOTAL_BITS-2:0], w_level_next};
      end else begin
        w_shift_next = w_shift_base;
      end
      if (w_cnt_base == LAST_IDX) begin
        w_cnt_next = {CNT_W{1'b0}};
        if (w_bit_base == LAST_BIT) begin
          w_bit_next   = {BIT_W{1'b0}};
          w_state_next = ST_CHECK;
        end else begin
          w_bit_next = w_bit_base + BIT_ONE;
        end
      end else begin
        w_cnt_next = w_cnt_base + CNT_ONE;
      end
    end else begin
      w_cnt_next   = w_cnt_base;
      w_bit_next   = w_bit_base;
      w_shift_next = w_shift_base;
    end
  end

  // Slicer level register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_level <= 1'b0;
    end else begin
      r_level <= w_level_next;
    end
  end

  // Receive state: FSM, counters, shift register and busy flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= {CNT_W{1'b0}};
      r_bit_cnt    <= {BIT_W{1'b0}};
      r_shift      <= {TOTAL_BITS{1'b0}};
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sample_cnt <= w_cnt_next;
      r_bit_cnt    <= w_bit_next;
      r_shift      <= w_shift_next;
      r_busy       <= (w_state_next == ST_RECEIVE);
    end
  end

  // CHECK cycle: capture the verdict and payload field before a new line can overwrite the shift register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_chk_done    <= 1'b0;
      r_chk_id_ok   <= 1'b0;
      r_chk_payload <= {PAYLOAD_BITS{1'b0}};
`ifdef SEQ_DET_CRC_EN
      r_chk_crc_ok  <= 1'b0;
`endif
    end else begin
      r_chk_done    <= (r_state == ST_CHECK);
      r_chk_id_ok   <= (w_header == ID_VALUE);
      r_chk_payload <= w_payload_field;
`ifdef SEQ_DET_CRC_EN
      r_chk_crc_ok  <= (crc8_msb(r_shift[TOTAL_BITS-1 -: MSG_W]) == r_shift[7:0]);
`endif
    end
  end

  // Result outputs: header mismatch wins over CRC mismatch; a failed line leaves the old payload in place.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_payload       <= {PAYLOAD_BITS{1'b0}};
      r_payload_valid <= 1'b0;
      r_id_error      <= 1'b0;
      r_ready         <= 1'b0;
`ifdef SEQ_DET_CRC_EN
      r_crc_error     <= 1'b0;
`endif
    end else begin
      r_payload_valid <= 1'b0;
      r_id_error      <= 1'b0;
`ifdef SEQ_DET_CRC_EN
      r_crc_error     <= 1'b0;
`endif
      if (r_chk_done) begin
        if (!r_chk_id_ok) begin
          r_id_error <= 1'b1;
          r_ready    <= 1'b0;
`ifdef SEQ_DET_CRC_EN
        end else if (!r_chk_crc_ok) begin
          r_crc_error <= 1'b1;
          r_ready     <= 1'b0;
`endif
        end else begin
          r_payload       <= r_chk_payload;
          r_payload_valid <= 1'b1;
          r_ready         <= 1'b1;
        end
      end else begin
        r_payload <= r_payload;
        r_ready   <= r_ready;
      end
    end
  end

  assign o_payload       = r_payload;
  assign o_payload_valid = r_payload_valid;
  assign o_id_error      = r_id_error;
  assign o_ready         = r_ready;
  assign o_busy          = r_busy;
`ifdef SEQ_DET_CRC_EN
  assign o_crc_error     = r_crc_error;
`else
  assign o_crc_error     = 1'b0;
`endif

endmodule

// File: tb/tb_line_sequence_decoder.sv
// Self-checking bench for line_sequence_decoder: directed lines plus randomized
// lines (noise samples, valid gaps), checked against a behavioural model that
// slices each sample, reads the middle of every bit cell and judges the line.
`timescale 1ns/1ps
module tb_line_sequence_decoder;
`ifdef SEQ_DET_CRC_EN
  localparam int TB_TOTAL = 48;
`else
  localparam int TB_TOTAL = 40;
`endif
  localparam int SPB  = 720 / TB_TOTAL;
  localparam int MID  = SPB / 2 - 1;
  localparam int HI_T = 'h3AC - 'h100;
  localparam int LO_T = 'h040 + 'h100;

  logic        clk;
  logic        rst;
  logic [9:0]  smp;
  logic        sv;
  logic        ls;
  logic [31:0] o_payload;
  logic        o_payload_valid;
  logic        o_id_error;
  logic        o_crc_error;
  logic        o_ready;
  logic        o_busy;

  line_sequence_decoder dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_sample_in    (smp),
    .i_sample_valid (sv),
    .i_line_start   (ls),
    .o_payload      (o_payload),
    .o_payload_valid(o_payload_valid),
    .o_id_error     (o_id_error),
    .o_crc_error    (o_crc_error),
    .o_ready        (o_ready),
    .o_busy         (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cnt_pv = 0;
  int cnt_id = 0;
  int cnt_crc = 0;
  int s_pv, s_id, s_crc;
  logic                m_level;
  logic [TB_TOTAL-1:0] m_dec;
  logic [31:0]         m_payload;
  logic                m_ready;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_payload_valid) cnt_pv = cnt_pv + 1;
    if (o_id_error)      cnt_id = cnt_id + 1;
    if (o_crc_error)     cnt_crc = cnt_crc + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef SEQ_DET_CRC_EN
  // CRC as the remainder of msg * x^8 divided by x^8+x^2+x+1 (long division).
  function automatic logic [7:0] crc_ref(input logic [39:0] msg);
    logic [47:0] r;
    r = {msg, 8'h00};
    for (int i = 47; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction
`endif

  function automatic logic [TB_TOTAL-1:0] make_bits(input logic [7:0] id, input logic [31:0] pay, input logic bad_crc);
`ifdef SEQ_DET_CRC_EN
    logic [7:0] flip;
    flip = bad_crc ? 8'($urandom_range(1, 255)) : 8'h00;
    return {id, pay, crc_ref({id, pay}) ^ flip};
`else
    return bad_crc ? {id, pay} : {id, pay};
`endif
  endfunction

  function automatic logic [9:0] sample_for(input logic v, input int j, input int mode, input int noise);
    logic [9:0] r;
    case (mode)
      1: r = (j == 0) ? (v ? 10'h3AC : 10'h040) : 10'h200;
      2: r = v ? ((j == 0) ? 10'h2AD : 10'h2AC) : ((j == 0) ? 10'h13F : 10'h140);
      3: r = v ? ((j == 0) ? 10'h3AC : 10'h140) : ((j == 0) ? 10'h040 : 10'h2AC);
      default: begin
        if (noise > 0 && $urandom_range(0, 99) < noise) r = 10'($urandom_range(0, 1023));
        else r = v ? 10'h3AC : 10'h040;
      end
    endcase
    return r;
  endfunction

  // Present one cycle of inputs, advance the slicer model, then step past the edge.
  task automatic drive(input logic [9:0] val, input logic valid, input logic start);
    smp = val;
    sv  = valid;
    ls  = start;
    if (rst) m_level = 1'b0;
    else if (valid) begin
      if (int'(val) > HI_T) m_level = 1'b1;
      else if (int'(val) < LO_T) m_level = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_pv = cnt_pv;
    s_id = cnt_id;
    s_crc = cnt_crc;
  endtask

  task automatic send_line(input logic [TB_TOTAL-1:0] bits, input int mode, input int gap,
                           input int noise, input bit ls_first, input int n_samples);
    int b;
    int j;
    logic v;
    m_dec = '0;
    if (!ls_first) drive(10'h000, 1'b0, 1'b1);
    for (int s = 0; s < n_samples; s++) begin
      b = s / SPB;
      j = s % SPB;
      v = bits[TB_TOTAL-1-b];
      if ((gap == 1 && s > 0) || (gap == 2 && $urandom_range(0, 3) == 0))
        drive(10'($urandom_range(0, 1023)), 1'b0, 1'b0);
      drive(sample_for(v, j, mode, noise), 1'b1, ls_first && (s == 0));
      if (j == MID) m_dec[TB_TOTAL-1-b] = m_level;
      if (s == 100) check_eq("busy_mid_line", {63'd0, o_busy}, 64'd1);
    end
  endtask

  // Judge the decoded line as the model sees it and check timing, flags and pulse counts.
  task automatic check_result(input string tag);
    logic        exp_id;
    logic        exp_crc;
    logic        exp_pass;
    logic [31:0] field;
    field   = m_dec[TB_TOTAL-9 -: 32];
    exp_id  = (m_dec[TB_TOTAL-1 -: 8] != 8'hA5);
    exp_crc = 1'b0;
`ifdef SEQ_DET_CRC_EN
    if (!exp_id) exp_crc = (crc_ref(m_dec[47:8]) != m_dec[7:0]);
`endif
    exp_pass = !exp_id && !exp_crc;
    drive(10'h000, 1'b0, 1'b0);
    check_eq({tag, "_early"}, {61'd0, o_payload_valid, o_id_error, o_crc_error}, 64'd0);
    drive(10'h000, 1'b0, 1'b0);
    check_eq({tag, "_pv"}, {63'd0, o_payload_valid}, {63'd0, exp_pass});
    check_eq({tag, "_iderr"}, {63'd0, o_id_error}, {63'd0, exp_id});
    check_eq({tag, "_crcerr"}, {63'd0, o_crc_error}, {63'd0, exp_crc});
    if (exp_pass) m_payload = field;
    m_ready = exp_pass;
    check_eq({tag, "_payload"}, {32'd0, o_payload}, {32'd0, m_payload});
    check_eq({tag, "_ready"}, {63'd0, o_ready}, {63'd0, m_ready});
    check_eq({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    drive(10'h000, 1'b0, 1'b0);
    check_eq({tag, "_pulse_end"}, {61'd0, o_payload_valid, o_id_error, o_crc_error}, 64'd0);
    check_eq({tag, "_npv"}, 64'(cnt_pv - s_pv), {63'd0, exp_pass});
    check_eq({tag, "_nid"}, 64'(cnt_id - s_id), {63'd0, exp_id});
    check_eq({tag, "_ncrc"}, 64'(cnt_crc - s_crc), {63'd0, exp_crc});
  endtask

  initial begin
    logic [7:0]  hdr;
    logic [31:0] pay;
    smp = 10'h000; sv = 1'b0; ls = 1'b0;
    m_level = 1'b0; m_payload = 32'h0; m_ready = 1'b0; m_dec = '0;
    rst = 1'b1;
    drive(10'h000, 1'b0, 1'b0);
    drive(10'h000, 1'b0, 1'b0);
    check_eq("reset_state", {o_payload, 26'd0, o_payload_valid, o_id_error, o_crc_error, o_ready, o_busy, 1'b0}, 64'd0);
    rst = 1'b0;

    // Clean line A5 / DEADBEEF
    snap();
    send_line(make_bits(8'hA5, 32'hDEADBEEF, 1'b0), 0, 0, 0, 1'b0, 720);
    check_result("t2_good");
    check_eq("t2_payload_const", {32'd0, o_payload}, {32'd0, 32'hDEADBEEF});

    // Wrong header: id_error, payload holds
    snap();
    send_line(make_bits(8'h5A, 32'h12345678, 1'b0), 0, 0, 0, 1'b0, 720);
    check_result("t3_badid");
    check_eq("t3_payload_held", {32'd0, o_payload}, {32'd0, 32'hDEADBEEF});
    check_eq("t3_ready_low", {63'd0, o_ready}, 64'd0);

    // Reset mid-line after a good line
    snap();
    send_line(make_bits(8'hA5, 32'hCAFEF00D, 1'b0), 0, 0, 0, 1'b0, 720);
    check_result("t1_pre");
    snap();
    send_line(make_bits(8'hA5, 32'h0BADF00D, 1'b0), 0, 0, 0, 1'b0, 300);
    rst = 1'b1;
    drive(10'h3AC, 1'b1, 1'b0);
    drive(10'h040, 1'b1, 1'b0);
    check_eq("t1_reset_outputs", {o_payload, 26'd0, o_payload_valid, o_id_error, o_crc_error, o_ready, o_busy, 1'b0}, 64'd0);
    rst = 1'b0;
    m_payload = 32'h0;
    m_ready = 1'b0;
    for (int s = 0; s < 420; s++) drive(((s / SPB) % 2 == 0) ? 10'h3AC : 10'h040, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) drive(10'h000, 1'b0, 1'b0);
    check_eq("t1_no_pulse", 64'((cnt_pv - s_pv) + (cnt_id - s_id) + (cnt_crc - s_crc)), 64'd0);
    check_eq("t1_idle_busy", {63'd0, o_busy}, 64'd0);

    // Hysteresis patterns
    snap();
    send_line(make_bits(8'hA5, 32'h13579BDF, 1'b0), 1, 0, 0, 1'b0, 720);
    check_result("t4_mid_hold");
    check_eq("t4_mid_payload", {32'd0, o_payload}, {32'd0, 32'h13579BDF});
    snap();
    send_line(make_bits(8'hA5, 32'h2468ACE0, 1'b0), 2, 0, 0, 1'b0, 720);
    check_result("t4_edge_trig");
    check_eq("t4_edge_payload", {32'd0, o_payload}, {32'd0, 32'h2468ACE0});
    snap();
    send_line(make_bits(8'hA5, 32'h5A5AC3C3, 1'b0), 3, 0, 0, 1'b0, 720);
    check_result("t4_edge_hold");
    check_eq("t4_hold_payload", {32'd0, o_payload}, {32'd0, 32'h5A5AC3C3});

    // Alternating valid, line_start coincident with sample 0
    snap();
    send_line(make_bits(8'hA5, 32'hDEADBEEF, 1'b0), 0, 1, 0, 1'b1, 720);
    check_result("t5_gaps");
    check_eq("t5_payload", {32'd0, o_payload}, {32'd0, 32'hDEADBEEF});

    // Line restarted after 300 samples: exactly one result
    snap();
    send_line(make_bits(8'hA5, 32'h11111111, 1'b0), 0, 0, 0, 1'b0, 300);
    send_line(make_bits(8'hA5, 32'h0F1E2D3C, 1'b0), 0, 0, 0, 1'b1, 720);
    check_result("t6_restart");
    check_eq("t6_payload", {32'd0, o_payload}, {32'd0, 32'h0F1E2D3C});
`ifdef SEQ_DET_CRC_EN
    snap();
    send_line(make_bits(8'hA5, 32'h76543210, 1'b1), 0, 0, 0, 1'b0, 720);
    check_result("t6_badcrc");
    check_eq("t6_crc_pulse_seen", 64'(cnt_crc - s_crc), 64'd1);
    check_eq("t6_crc_payload_held", {32'd0, o_payload}, {32'd0, 32'h0F1E2D3C});
`endif

    // Randomized lines
    for (int n = 0; n < 16; n++) begin
      hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA5;
      pay = 32'($urandom);
      snap();
      send_line(make_bits(hdr, pay, ($urandom_range(0, 3) == 0)),
                0, int'($urandom_range(0, 2)), int'($urandom_range(0, 12)),
                1'($urandom_range(0, 1)), 720);
      check_result("rand_line");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
